layer_pingpong_sched: RTL and testbench

//  Sequencer for one fully-connected layer datapath (input buffer, W/B ROMs, MAC+ReLU) with a
//  two-bank ping-pong input buffer: vector k+1 streams in while vector k is computed.

---
 rtl/layer_sched_pkg.sv | 37 +++
 rtl/xbuf_bank_ctrl.sv | 65 ++++++
 rtl/layer_pingpong_sched.sv | 131 +++++++++++++
 tb/tb_layer_pingpong_sched.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_sched_pkg.sv
// ============================================================================
// Module : layer_sched_pkg
// Brief  : Shared state encoding, width helpers and default sizes for the
//          ping-pong fully-connected layer sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package layer_sched_pkg;

    localparam int DEF_M = 13;
    localparam int DEF_N = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BIAS  = 3'd1,
        MAC   = 3'd2,
        DRAIN = 3'd3,
        OUT   = 3'd4
    } state_t;

    // Input-buffer address: one extra MSB selects the bank.
    function automatic int xaw_f(input int n);
        return $clog2(n) + 1;
    endfunction

    function automatic int waw_f(input int m, input int n);
        return (m * n > 1) ? $clog2(m * n) : 1;
    endfunction

    function automatic int baw_f(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/xbuf_bank_ctrl.sv
// ============================================================================
// Module : xbuf_bank_ctrl
// Brief  : Two-bank input-buffer bookkeeping: write pointer, bank-full flags
//          and read-bank selection for the compute side.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module xbuf_bank_ctrl #(
    parameter int N   = 16,
    parameter int XAW = 5
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           s_valid,
    input  logic           rel_pulse,
    output logic           s_ready,
    output logic           x_wr_en,
    output logic [XAW-1:0] x_wr_addr,
    output logic           rd_avail,
    output logic           rbank
);

    localparam int CW = XAW - 1;

    logic [1:0]    full;
    logic          wbank;
    logic [CW-1:0] wcnt;
    logic          run;

    // run keeps s_ready low while reset is held and for the release edge.
    assign s_ready   = run & ~full[wbank];
    assign x_wr_en   = s_valid & s_ready;
    assign x_wr_addr = {wbank, wcnt};
    assign rd_avail  = full[rbank];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full  <= 2'b00;
            wbank <= 1'b0;
            rbank <= 1'b0;
            wcnt  <= '0;
            run   <= 1'b0;
        end else begin
            run <= 1'b1;
            if (x_wr_en) begin
                if (wcnt == CW'(N - 1)) begin
                    full[wbank] <= 1'b1;
                    wbank       <= ~wbank;
                    wcnt        <= '0;
                end else begin
                    wcnt <= wcnt + CW'(1);
                end
            end
            // A write only targets a non-full bank, so it never collides with this.
            if (rel_pulse) begin
                full[rbank] <= 1'b0;
                rbank       <= ~rbank;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/layer_pingpong_sched.sv
// ============================================================================
// Module : layer_pingpong_sched
// Brief  : Compute sequencer for one FC layer with a ping-pong input buffer.
//          LAYER_SCHED_RELU_EN enables the relu_check strobe in DRAIN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module layer_pingpong_sched
    import layer_sched_pkg::*;
#(
    parameter int M   = DEF_M,
    parameter int N   = DEF_N,
    parameter int XAW = xaw_f(N),
    parameter int WAW = waw_f(M, N),
    parameter int BAW = baw_f(M)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           s_valid,
    output logic           s_ready,
    output logic           x_wr_en,
    output logic [XAW-1:0] x_wr_addr,
    output logic [XAW-1:0] x_rd_addr,
    output logic [WAW-1:0] w_addr,
    output logic [BAW-1:0] b_addr,
    output logic           acc_load,
    output logic           acc_en,
    output logic           relu_check,
    output logic           m_valid,
    input  logic           m_ready,
    output logic           busy
);

    localparam int CW = XAW - 1;

`ifdef LAYER_SCHED_RELU_EN
    localparam logic RELU_ON = 1'b1;
`else
    localparam logic RELU_ON = 1'b0;
`endif

    state_t        state;
    logic [CW-1:0] col;
    logic          rd_avail;
    logic          rbank;
    logic          rel_pulse;

    // b_addr doubles as the row counter.
    assign rel_pulse = (state == OUT) && m_ready && (b_addr == BAW'(M - 1));
    assign busy      = (state != IDLE);

    xbuf_bank_ctrl #(
        .N   (N),
        .XAW (XAW)
    ) u_xbuf_bank_ctrl (
        .clk       (clk),
        .reset     (reset),
        .s_valid   (s_valid),
        .rel_pulse (rel_pulse),
        .s_ready   (s_ready),
        .x_wr_en   (x_wr_en),
        .x_wr_addr (x_wr_addr),
        .rd_avail  (rd_avail),
        .rbank     (rbank)
    );

    // Strobes are registered one state ahead to match the 1-cycle memory latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            col        <= '0;
            x_rd_addr  <= '0;
            w_addr     <= '0;
            b_addr     <= '0;
            acc_load   <= 1'b0;
            acc_en     <= 1'b0;
            relu_check <= 1'b0;
            m_valid    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_avail) begin
                        state  <= BIAS;
                        b_addr <= '0;
                    end
                end
                BIAS: begin
                    state     <= MAC;
                    col       <= '0;
                    x_rd_addr <= {rbank, CW'(0)};
                    w_addr    <= WAW'(int'(b_addr) * N);
                    acc_load  <= 1'b1;
                end
                MAC: begin
                    acc_load <= 1'b0;
                    acc_en   <= 1'b1;
                    if (col == CW'(N - 1)) begin
                        state      <= DRAIN;
                        relu_check <= RELU_ON;
                    end else begin
                        col       <= col + CW'(1);
                        x_rd_addr <= {rbank, col + CW'(1)};
                        w_addr    <= w_addr + WAW'(1);
                    end
                end
                DRAIN: begin
                    state      <= OUT;
                    acc_en     <= 1'b0;
                    relu_check <= 1'b0;
                    m_valid    <= 1'b1;
                end
                OUT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        if (b_addr == BAW'(M - 1)) begin
                            state <= IDLE;
                        end else begin
                            state  <= BIAS;
                            b_addr <= b_addr + BAW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_layer_pingpong_sched.sv
// ============================================================================
// Module : tb_layer_pingpong_sched
// Brief  : Directed bench with a behavioural FC datapath driven by the DUT strobes.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_layer_pingpong_sched;

    localparam int M   = 13;
    localparam int N   = 16;
    localparam int XAW = 5;
    localparam int WAW = 8;
    localparam int BAW = 4;
`ifdef LAYER_SCHED_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           s_valid = 1'b0;
    logic           m_ready = 1'b1;
    logic           s_ready, x_wr_en, acc_load, acc_en, relu_check, m_valid, busy;
    logic [XAW-1:0] x_wr_addr, x_rd_addr;
    logic [WAW-1:0] w_addr;
    logic [BAW-1:0] b_addr;

    always #5 clk = ~clk;

    layer_pingpong_sched #(.M(M), .N(N), .XAW(XAW), .WAW(WAW), .BAW(BAW)) dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
        .x_wr_en(x_wr_en), .x_wr_addr(x_wr_addr), .x_rd_addr(x_rd_addr),
        .w_addr(w_addr), .b_addr(b_addr), .acc_load(acc_load), .acc_en(acc_en),
        .relu_check(relu_check), .m_valid(m_valid), .m_ready(m_ready), .busy(busy)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Behavioural datapath: W row 12 is zero with bias -5, every other weight is 1, bias = row.
    logic signed [15:0] xmem [0:31];
    logic signed [15:0] wrom [0:M*N-1];
    logic signed [15:0] brom [0:M-1];
    logic signed [15:0] x_q, w_q, b_q, s_data;
    logic signed [31:0] acc;

    initial begin
        for (int i = 0; i < M*N; i++) wrom[i] = (i / N == 12) ? 16'sd0 : 16'sd1;
        for (int r = 0; r < M; r++) brom[r] = (r == 12) ? -16'sd5 : 16'(r);
    end

    function automatic logic signed [31:0] step(input logic signed [31:0] a,
            input logic signed [15:0] w, input logic signed [15:0] x, input logic clamp);
        logic signed [31:0] s;
        s = a + w * x;
        return (clamp && s < 0) ? 32'sd0 : s;
    endfunction

    always @(posedge clk) begin
        if (x_wr_en) xmem[x_wr_addr] <= s_data;
        x_q <= xmem[x_rd_addr];
        w_q <= wrom[w_addr];
        b_q <= brom[b_addr];
        if (acc_load)    acc <= 32'(b_q);
        else if (acc_en) acc <= step(acc, w_q, x_q, relu_check);
    end

    // Word i of a test run carries (i%16)+1+(i/16): vector v sums to 136+16v.
    function automatic logic signed [15:0] word_val(input int i);
        return 16'((i % N) + 1 + (i / N));
    endfunction

    function automatic longint exp_out(input int v, input int r);
        if (r == 12) return RELU ? 0 : -5;
        return r + 136 + 16 * v;
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc++;

    int  out_count, low_cnt, last_wr, exp_w, exp_b, exp_wa, prev_w, prev_b;
    int  wseq_err, wseq_n, bseq_err, strobe_err, relu_n, wa_err, frz_err, stall_n;
    bit  prev_mv, lat_chk, stall_en, rerise_chk, rerise_pend, stall;
    logic [48:0] snap;

    always @(negedge clk) begin
        if (!reset) begin
            out_count = 0; low_cnt = 0; exp_w = 0; exp_b = 0; exp_wa = 0;
            prev_w = 0; prev_b = 0; prev_mv = 0; wseq_err = 0; wseq_n = 0;
            bseq_err = 0; strobe_err = 0; relu_n = 0; wa_err = 0; frz_err = 0;
            rerise_pend = 0; m_ready = 1'b1;
        end else begin
            stall = stall_en && m_valid && out_count == 3 && stall_n < 5;
            if (stall) begin
                if (stall_n == 0) snap = {w_addr, b_addr, x_rd_addr, acc};
                else if (snap != {w_addr, b_addr, x_rd_addr, acc}) frz_err++;
                if (acc_en || acc_load || !m_valid) frz_err++;
                stall_n++;
            end
            m_ready = !stall;
            if (rerise_pend) begin
                check("s_ready_rerise", s_ready, 1);
                rerise_pend = 0;
            end
            if (x_wr_en) begin
                last_wr = cyc;
                if (int'(x_wr_addr) != exp_wa) wa_err++;
                exp_wa = (exp_wa + 1) % 32;
            end
            if (acc_load && acc_en) strobe_err++;
            if (acc_en) begin
                if (prev_w != exp_w) wseq_err++;
                exp_w = (exp_w + 1) % (M * N);
                wseq_n++;
            end
            if (acc_load) begin
                if (prev_b != exp_b) bseq_err++;
                if (exp_b == 0) check("rd_bank", x_rd_addr[XAW-1], (out_count / M) % 2);
                exp_b = (exp_b + 1) % M;
            end
            if (relu_check) relu_n++;
            if (m_valid && !prev_mv && lat_chk) begin
                if (out_count == 0) check("latency", cyc - last_wr - 1, N + 3);
                else                check("out_gap", low_cnt, N + 2);
            end
            low_cnt = m_valid ? 0 : low_cnt + 1;
            if (m_valid && m_ready) begin
                check("out_val", acc, exp_out(out_count / M, out_count % M));
                if (rerise_chk && out_count == M - 1) begin
                    check("s_ready_full", s_ready, 0);
                    rerise_pend = 1;
                end
                out_count++;
            end
            prev_mv = m_valid;
            prev_w  = int'(w_addr);
            prev_b  = int'(b_addr);
        end
    end

    function automatic logic [28:0] all_outs();
        return {s_ready, x_wr_en, x_wr_addr, x_rd_addr, w_addr, b_addr,
                acc_load, acc_en, relu_check, m_valid, busy};
    endfunction

    int drop_at;

    task automatic do_reset();
        reset = 1'b0;
        s_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outs", all_outs(), 0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("s_ready_after_rst", s_ready, 1);
    endtask

    task automatic write_words(input int n, input bit toggle, input bit track);
        int i = 0;
        int t = 0;
        bit ph = 1'b0;
        while (i < n && t < 3000) begin
            @(negedge clk);
            ph = toggle ? ~ph : 1'b1;
            s_valid = ph;
            s_data  = word_val(i);
            if (track && !s_ready && drop_at < 0) drop_at = i;
            if (s_valid && s_ready) i++;
            t++;
        end
        @(negedge clk);
        s_valid = 1'b0;
        if (t >= 3000) check("write_timeout", i, n);
    endtask

    task automatic wait_outs(input int n);
        int t = 0;
        while (out_count < n && t < 4000) begin
            @(negedge clk);
            t++;
        end
        check("out_count", out_count, n);
        @(negedge clk);
        check("idle_after", busy, 0);
    endtask

    initial begin
        lat_chk = 0; stall_en = 0; rerise_chk = 0; stall_n = 0; drop_at = -1;
        s_data = '0;

        // One vector back-to-back, downstream always ready.
        do_reset();
        lat_chk = 1;
        write_words(16, 1'b0, 1'b0);
        wait_outs(M);
        lat_chk = 0;
        check("w_seq_err", wseq_err, 0);
        check("w_seq_len", wseq_n, M * N);
        check("b_seq_err", bseq_err, 0);
        check("strobe_both", strobe_err, 0);
        check("relu_pulses", relu_n, RELU ? M : 0);

        // Three vectors streamed continuously with a 5-cycle downstream stall.
        do_reset();
        stall_en = 1; stall_n = 0; rerise_chk = 1; drop_at = -1;
        write_words(48, 1'b0, 1'b1);
        wait_outs(3 * M);
        check("s_ready_drop_at", drop_at, 32);
        check("stall_cycles", stall_n, 5);
        check("stall_frozen", frz_err, 0);
        check("w_seq_err3", wseq_err, 0);
        check("w_seq_len3", wseq_n, 3 * M * N);
        check("b_seq_err3", bseq_err, 0);
        check("wr_addr_err3", wa_err, 0);
        stall_en = 0; rerise_chk = 0;

        // Asynchronous reset in row 4 col 7, then a toggling-valid vector.
        do_reset();
        write_words(16, 1'b0, 1'b0);
        begin
            int t = 0;
            while (!(b_addr == 4'd4 && acc_en && x_rd_addr[XAW-2:0] == 4'd7) && t < 2000) begin
                @(negedge clk);
                t++;
            end
            check("reach_row4_col7", t < 2000, 1);
        end
        #2 reset = 1'b0;
        #1 check("async_reset_outs", all_outs(), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("s_ready_post_async", s_ready, 1);
        write_words(16, 1'b1, 1'b0);
        wait_outs(M);
        check("wr_addr_contig", wa_err, 0);
        check("wr_addr_count", exp_wa, 16);
        check("w_seq_len_r", wseq_n, M * N);
        check("strobe_both_r", strobe_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
